clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_pkg.sv | 14 +
 rtl/clock_set_timeout.sv | 34 +++
 rtl/clock_set_ctrl.sv | 125 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and defaults for the clock set controller.
// Holds the mode/state enum and the TIMEOUT_TICKS default.
package clock_pkg;

  localparam int unsigned TIMEOUT_TICKS_DEF = 30;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10,
    ST_BAD      = 2'b11
  } state_e;

endpackage

// File: rtl/clock_set_timeout.sv
// Idle counter for the set modes: counts ticks, flags timeout.
// Ports: clk, reset, clear, tick, limit[7:0] in; expired out.
module clock_set_timeout (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the tick that would take the count past limit.
  assign expired = tick & (cnt_q == limit);

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM and counter enable decode for a settable HH:MM:SS clock.
// In: clk, reset, tick_1hz, btn_mode, btn_inc, sec_max, min_max.
// Out: sec_en, min_en, hr_en, sec_clr, mode[1:0], blink_hr, blink_min.
// Option: CLOCK_SET_BLINK_EN adds a 1 Hz blink phase to the blink outputs.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_max,
  input  logic       min_max,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink_hr,
  output logic       blink_min
);

  state_e state_q, state_d;
  logic   sec_clr_q, sec_clr_d;
  logic   expired;
  logic   idle_clr;
  logic   in_set;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_TICKS - 1);

  assign in_set = (state_q == ST_SET_HOUR) | (state_q == ST_SET_MIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (btn_mode) state_d = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        // Timeout wins over a same-cycle btn_mode: no double advance.
        if (expired)       state_d = ST_RUN;
        else if (btn_mode) state_d = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        if (expired | btn_mode) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign sec_clr_d = (state_q == ST_SET_MIN) & (state_d == ST_RUN);
  assign idle_clr  = ~in_set | btn_inc | (state_d != state_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      sec_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_clr_q <= sec_clr_d;
    end
  end

  clock_set_timeout u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (idle_clr),
    .tick    (tick_1hz & in_set),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Zero-latency enables so the counters move on the same edge.
  always_comb begin
    sec_en = 1'b0;
    min_en = 1'b0;
    hr_en  = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          sec_en = tick_1hz;
          min_en = tick_1hz & sec_max;
          hr_en  = tick_1hz & sec_max & min_max;
        end
        ST_SET_HOUR: hr_en  = btn_inc & ~btn_mode;
        ST_SET_MIN:  min_en = btn_inc & ~btn_mode;
        default: ;
      endcase
    end
  end

  assign sec_clr = sec_clr_q;
  assign mode    = state_q;

`ifdef CLOCK_SET_BLINK_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (state_d != state_q) begin
      phase_d = 1'b0;
    end else if (in_set & tick_1hz) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign blink_hr  = (state_q == ST_SET_HOUR) & phase_q;
  assign blink_min = (state_q == ST_SET_MIN) & phase_q;
`else
  assign blink_hr  = (state_q == ST_SET_HOUR);
  assign blink_min = (state_q == ST_SET_MIN);
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl, default TIMEOUT_TICKS=30.
// Honours CLOCK_SET_BLINK_EN when choosing blink expectations.
module tb_clock_set_ctrl;

`ifdef CLOCK_SET_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       sec_max;
  logic       min_max;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blink_hr;
  logic       blink_min;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .sec_max   (sec_max),
    .min_max   (min_max),
    .sec_en    (sec_en),
    .min_en    (min_en),
    .hr_en     (hr_en),
    .sec_clr   (sec_clr),
    .mode      (mode),
    .blink_hr  (blink_hr),
    .blink_min (blink_min)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge; outputs settle 1 ns later.
  task automatic drive(input logic t, input logic m, input logic i);
    @(negedge clk);
    tick_1hz = t;
    btn_mode = m;
    btn_inc  = i;
    #1;
  endtask

  function automatic logic exp_blink(input logic p);
    return BLINK ? p : 1'b1;
  endfunction

  initial begin
    reset    = 1'b1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    sec_max  = 1'b0;
    min_max  = 1'b0;

    // Reset state, and enables held low under reset.
    @(negedge clk);
    tick_1hz = 1'b1; sec_max = 1'b1; min_max = 1'b1;
    #1;
    chk("rst_mode", 8'(mode), 8'd0);
    chk("rst_secclr", 8'(sec_clr), 8'd0);
    chk("rst_en", 8'({sec_en, min_en, hr_en}), 8'd0);
    chk("rst_blink", 8'({blink_hr, blink_min}), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    tick_1hz = 1'b0;

    // RUN: full carry chain.
    drive(1, 0, 0);
    chk("run_carry", 8'({sec_en, min_en, hr_en}), 8'b111);
    drive(0, 0, 0);
    chk("run_mode", 8'(mode), 8'd0);

    // RUN: seconds only, then seconds into minutes.
    sec_max = 1'b0; min_max = 1'b0;
    drive(1, 0, 0);
    chk("run_sec", 8'({sec_en, min_en, hr_en}), 8'b100);
    sec_max = 1'b1;
    drive(1, 0, 0);
    chk("run_min", 8'({sec_en, min_en, hr_en}), 8'b110);

    // RUN ignores btn_inc.
    drive(0, 0, 1);
    chk("run_inc", 8'({sec_en, min_en, hr_en}), 8'b000);
    drive(0, 0, 0);
    chk("run_inc_mode", 8'(mode), 8'd0);

    // Enter SET_HOUR; check blink sequence and frozen seconds.
    drive(0, 1, 0);
    drive(0, 0, 0);
    chk("sh_mode", 8'(mode), 8'd1);
    chk("sh_blink0", 8'(blink_hr), 8'(exp_blink(1'b0)));
    chk("sh_blinkmin", 8'(blink_min), 8'd0);
    drive(1, 0, 0);
    chk("sh_tick_en", 8'({sec_en, min_en, hr_en}), 8'b000);
    drive(0, 0, 0);
    chk("sh_blink1", 8'(blink_hr), 8'(exp_blink(1'b1)));
    drive(1, 0, 0);
    drive(0, 0, 0);
    chk("sh_blink2", 8'(blink_hr), 8'(exp_blink(1'b0)));

    // Three increments, each a single-cycle hr_en.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1);
      chk("sh_inc", 8'({sec_en, min_en, hr_en}), 8'b001);
      drive(0, 0, 0);
      chk("sh_inc_gap", 8'(hr_en), 8'd0);
    end
    chk("sh_mode2", 8'(mode), 8'd1);

    // btn_mode beats btn_inc.
    drive(0, 1, 1);
    chk("sh_prio_en", 8'(hr_en), 8'd0);
    drive(0, 0, 0);
    chk("sh_prio_mode", 8'(mode), 8'd2);
    chk("sh_prio_clr", 8'(sec_clr), 8'd0);
    chk("sm_blink", 8'(blink_min), 8'(exp_blink(1'b0)));

    // SET_MIN increment: no carry into hours, seconds frozen.
    drive(1, 0, 1);
    chk("sm_inc", 8'({sec_en, min_en, hr_en}), 8'b010);

    // Leave SET_MIN by button: one-cycle sec_clr.
    drive(0, 1, 0);
    drive(0, 0, 0);
    chk("sm_exit_mode", 8'(mode), 8'd0);
    chk("sm_exit_clr", 8'(sec_clr), 8'd1);
    drive(0, 0, 0);
    chk("sm_exit_clr1", 8'(sec_clr), 8'd0);

    // Timeout in SET_MIN, with btn_inc restarting the count.
    drive(0, 1, 0);
    drive(0, 1, 0);
    drive(0, 0, 0);
    chk("to_mode", 8'(mode), 8'd2);
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    drive(0, 0, 1);
    for (int k = 0; k < 29; k++) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    chk("to_29", 8'(mode), 8'd2);
    chk("to_29_clr", 8'(sec_clr), 8'd0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    chk("to_30_mode", 8'(mode), 8'd0);
    chk("to_30_clr", 8'(sec_clr), 8'd1);
    drive(0, 0, 0);
    chk("to_30_clr1", 8'(sec_clr), 8'd0);

    // Timeout in SET_HOUR with btn_mode on the same tick -> RUN.
    drive(0, 1, 0);
    drive(0, 0, 0);
    chk("toh_mode", 8'(mode), 8'd1);
    for (int k = 0; k < 29; k++) begin
      drive(1, 0, 0);
      drive(0, 0, 0);
    end
    chk("toh_29", 8'(mode), 8'd1);
    drive(1, 1, 0);
    drive(0, 0, 0);
    chk("toh_30", 8'(mode), 8'd0);
    chk("toh_clr", 8'(sec_clr), 8'd0);

    // Asynchronous reset in the middle of SET_MIN.
    drive(0, 1, 0);
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    chk("ar_pre", 8'(mode), 8'd2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_mode", 8'(mode), 8'd0);
    chk("ar_clr", 8'(sec_clr), 8'd0);
    chk("ar_blink", 8'({blink_hr, blink_min}), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0);
    chk("ar_after", 8'(sec_clr), 8'd0);
    chk("ar_after_mode", 8'(mode), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
